// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding: define REG_FILE_BYPASS_EN.
module reg_file_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] addr_wr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] data_wr,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] addr_rd,
   output logic [NUM_RD*DATA_WIDTH-1:0] data_rd,
   input  logic                         busy_set_en,
   input  logic [ADDR_WIDTH-1:0]        busy_set_addr,
   output logic [NUM_RD-1:0]            busy_rd,
   output logic [DEPTH-1:0]             busy_vec
);

   generate
      if (DEPTH != 2**ADDR_WIDTH) begin : g_bad_depth
         $error("reg_file_mp: DEPTH must equal 2**ADDR_WIDTH");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]      r_busy;

   logic [ADDR_WIDTH-1:0] w_waddr [NUM_WR];
   logic [DATA_WIDTH-1:0] w_wdata [NUM_WR];
   logic [NUM_WR-1:0]     w_wvld;
   logic [ADDR_WIDTH-1:0] w_raddr [NUM_RD];
   logic                  w_set_vld;
   logic [DEPTH-1:0]      w_busy_nxt;

   // Writes and busy-sets aimed at a hardwired x0 are dropped here.
   always_comb begin
      for (int k = 0; k < NUM_WR; k++) begin
         w_waddr[k] = addr_wr[k*ADDR_WIDTH +: ADDR_WIDTH];
         w_wdata[k] = data_wr[k*DATA_WIDTH +: DATA_WIDTH];
         w_wvld[k]  = wr_en[k] &&
                      !(ZERO_REG != 0 && w_waddr[k] == '0);
      end
      for (int p = 0; p < NUM_RD; p++) begin
         w_raddr[p] = addr_rd[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
      w_set_vld = busy_set_en &&
                  !(ZERO_REG != 0 && busy_set_addr == '0);
   end

   // A new producer outranks the completing one, so set follows clear.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int k = 0; k < NUM_WR; k++) begin
         if (w_wvld[k]) w_busy_nxt[w_waddr[k]] = 1'b0;
      end
      if (w_set_vld) w_busy_nxt[busy_set_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_busy <= '0;
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (w_wvld[k]) r_mem[w_waddr[k]] <= w_wdata[k];
         end
         r_busy <= w_busy_nxt;
      end
   end

   always_comb begin
      data_rd = '0;
      busy_rd = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         data_rd[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_raddr[p]];
         busy_rd[p] = r_busy[w_raddr[p]];
`ifdef REG_FILE_BYPASS_EN
         for (int k = 0; k < NUM_WR; k++) begin
            if (w_wvld[k] && w_waddr[k] == w_raddr[p]) begin
               data_rd[p*DATA_WIDTH +: DATA_WIDTH] = w_wdata[k];
               busy_rd[p] = busy_set_en &&
                            busy_set_addr == w_raddr[p];
            end
         end
`endif
         if (ZERO_REG != 0 && w_raddr[p] == '0) begin
            data_rd[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            busy_rd[p] = 1'b0;
         end
      end
   end

   assign busy_vec = r_busy;

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file with a per-register busy scoreboard. Successor to the single-write, dual-read register file.
- Sits in the decode/writeback stage of the RV32 core.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports.
- Busy bits let issue logic stall on pending writebacks.
- Configurable depth, width and x0 hardwiring.

Parameters:
DATA_WIDTH, 32, register width in bits
DEPTH, 32, number of registers (power of two, 2..64)
ADDR_WIDTH, $clog2(DEPTH), register index width
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2); higher index has priority
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/busy-set; 0 = register 0 is ordinary

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
wr_en  in  NUM_WR  per-port write enable
addr_wr  in  NUM_WR*ADDR_WIDTH  write indices, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
data_wr  in  NUM_WR*DATA_WIDTH  write data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
addr_rd  in  NUM_RD*ADDR_WIDTH  read indices, packed as for addr_wr
data_rd  out  NUM_RD*DATA_WIDTH  read data, packed
busy_set_en  in  1  mark one register pending (issue of a writing instruction)
busy_set_addr  in  ADDR_WIDTH  register to mark pending
busy_rd  out  NUM_RD  busy bit of each addr_rd register
busy_vec  out  DEPTH  full scoreboard snapshot

Behaviour:
- Interface: one clock, clk. rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising clk edge): all DEPTH registers and all busy bits become 0. Writes and busy_set in that cycle are ignored.
- Outputs are combinational from state, so after reset data_rd=0, busy_rd=0 and busy_vec=0.
- Read: data_rd[p] = reg[addr_rd[p]], combinational, zero latency. busy_rd[p] = busy[addr_rd[p]].
- Write: at the rising edge with wr_en[k]=1, reg[addr_wr[k]] <= data_wr[k]. The new value is visible on reads the next cycle (see optional bypass).
- Write-write collision: if both ports enable the same index, port NUM_WR-1 wins. Exactly one value is written; no OR-merge.
- Busy clear: any enabled write port clears busy[addr_wr[k]] at the same edge.
- Busy set: busy_set_en=1 sets busy[busy_set_addr] at the edge.
- Set/clear collision: set and clear of the same index in one cycle leaves busy=1. Set has priority because a new producer supersedes the completing one.
- ZERO_REG=1: writes to index 0 are dropped. busy_set to index 0 is dropped. Reads of index 0 return 0 and busy 0 regardless of bypass.
- Out-of-range index (DEPTH not a power of two is disallowed): never occurs. Guard with an elaboration-time check that errors if DEPTH != 2**ADDR_WIDTH.
- No internal FSM beyond the storage and scoreboard registers. All state updates on the rising edge only.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding in the same cycle.
  - If wr_en[k]=1 and addr_wr[k]==addr_rd[p], data_rd[p]=data_wr[k]. The highest-index matching port wins.
  - busy_rd[p] reflects the clear (reads 0) unless the same cycle also sets that index.
  - Index 0 with ZERO_REG=1 is never forwarded.
- Undefined: reads return the pre-edge stored value. Writeback data is visible one cycle later; busy_rd shows the pre-edge bit.

Test Plan:
1. Reset then read all indices: rst_n=0 for 2 cycles with wr_en=2'b11 active -> every data_rd=0, busy_vec=0.
2. Single write: cycle 1 wr_en[0]=1, addr_wr=5, data=0xDEADBEEF; cycle 2 addr_rd[0]=5 -> 0xDEADBEEF.
   - In cycle 1 with addr_rd[1]=5: returns 0xDEADBEEF if REG_FILE_BYPASS_EN is defined, 0 otherwise.
3. Write collision: both ports write index 7, port0=0x11111111, port1=0x22222222 -> reg7 reads 0x22222222.
4. Zero register: write 0xFFFFFFFF to index 0 and busy_set index 0 -> data_rd=0, busy_vec[0]=0 (ZERO_REG=1).
   - Same test with ZERO_REG=0 -> data_rd=0xFFFFFFFF, busy_vec[0]=1.
5. Scoreboard: busy_set index 3 -> busy_vec=0x00000008. Next cycle wr_en[1] index 3 plus busy_set index 3 -> still 0x00000008. Following cycle write-only index 3 -> busy_vec=0.
6. Parameter sweep: DEPTH=16, NUM_RD=4, NUM_WR=1, DATA_WIDTH=64.
   - Write 0x0123456789ABCDEF to index 15, read it on all 4 ports -> all return that value.
   - Reset mid-sequence clears it to 0.
